mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Two-port to one-bus memory arbiter placed between the multicycle MIPS core's instruction-fetch and data ports and a single shared Avalon-MM-style memory bus with `waitrequest`. It accepts one outstanding request per port and grants the bus round-robin when both ports request together. It holds bus signals stable across wait states and returns read data with a one-cycle acknowledge. An optional wait-state watchdog aborts hung transfers and flags a sticky error.

## Interface
Parameters:
- `WAIT_LIMIT`, default 255: maximum consecutive `waitrequest` cycles per transfer before abort. 0 disables the watchdog.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_req`  in  1  instruction fetch request; held until `instr_ack`.
- `instr_address`  in  32  fetch address; stable while `instr_req`.
- `instr_readdata`  out  32  fetched word; valid while `instr_ack`=1.
- `instr_ack`  out  1  one-cycle completion pulse.
- `data_read`  in  1  data load request.
- `data_write`  in  1  data store request; wins if asserted with `data_read`.
- `data_address`  in  32  data address.
- `data_writedata`  in  32  store data.
- `data_byteenable`  in  4  store/load lane enables.
- `data_readdata`  out  32  load result; valid while `data_ack`=1.
- `data_ack`  out  1  one-cycle completion pulse.
- `bus_address`  out  32  shared bus address.
- `bus_read`  out  1  bus read command.
- `bus_write`  out  1  bus write command.
- `bus_writedata`  out  32  bus store data.
- `bus_byteenable`  out  4  bus lane enables; 4'b1111 for fetches.
- `bus_waitrequest`  in  1  slave stall.
- `bus_readdata`  in  32  valid in cycle where `bus_read`=1 and `bus_waitrequest`=0.
- `bus_error`  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- States: IDLE, BUS_I, BUS_D, RESP.
- IDLE: sample requests. Only instr -> BUS_I. Only data -> BUS_D. Both -> grant the port not granted last (`last_grant` register). Neither -> stay.
- On entry to BUS_x, register address, command, writedata and byteenable onto the bus. Hold them unchanged every cycle `bus_waitrequest`=1.
- In BUS_x, cycle with `bus_waitrequest`=0 completes the transfer:
  - read: capture `bus_readdata` into the granted port's readdata register;
  - drop `bus_read`/`bus_write` on the next edge;
  - go to RESP and update `last_grant`.
- RESP: pulse the granted port's ack for exactly one cycle, then go to IDLE. Readdata registers keep their last value after ack.
- Requester contract: deassert the request on the edge that samples ack. A request still high in IDLE after RESP is treated as a new transfer.
- Watchdog: counter of consecutive wait cycles, width `$clog2(WAIT_LIMIT+1)`, cleared on entry to BUS_x. When it reaches `WAIT_LIMIT` with `waitrequest` still high:
  - drop the command;
  - load readdata with 32'h0;
  - set `bus_error`;
  - go to RESP (ack still pulses so the core does not hang).
- Data write+read together: perform write only.
- Reset, including mid-transfer: state IDLE; all outputs 0, including `bus_read`, `bus_write`, both acks and both readdata registers; `bus_error` 0; `last_grant`=DATA (instruction wins the first tie); counter 0. No ack is issued for the aborted transfer.

## Timing
- Request high at edge N (IDLE) -> bus command visible after edge N.
- Zero wait states: completion at edge N+1, ack high after edge N+2, IDLE after N+3.
- Minimum 3 cycles per transfer; each wait state adds one cycle.
- Competing request waits for RESP, then is granted in the following IDLE cycle.
- Bus outputs are registered; no combinational path from request inputs to bus outputs.
- Ack and readdata are registered; no combinational path from `bus_readdata`.

## Structure
- Shared package `mips_bus_pkg`: `arb_state_t` enum (IDLE, BUS_I, BUS_D, RESP) and `grant_t` enum (GRANT_I, GRANT_D), also used by the later bus wrapper of the core.
- No sub-module; the FSM, grant register, watchdog counter and output registers sit in one module.

## Test plan
- Single fetch, `instr_address`=32'hBFC00000, `waitrequest`=0, `bus_readdata`=32'h24020005 -> `bus_read` one cycle with `bus_byteenable`=4'hF, `instr_ack` pulse with `instr_readdata`=32'h24020005, 3 cycles total.
- Store `data_address`=32'h00001000, writedata 32'hDEADBEEF, byteenable 4'b0011, 2 wait states -> bus signals stable 3 cycles, `data_ack` after completion, no `instr_ack`.
- Both ports request together right after reset -> instruction granted first. Repeat the simultaneous request -> data granted, alternating.
- `WAIT_LIMIT`=4, `waitrequest` held high -> command drops after 4 wait cycles, ack pulses with readdata 0, `bus_error`=1 and stays 1 until reset.
- Reset asserted during BUS_D wait state -> next cycle `bus_write`=0 with no ack. A post-reset fetch behaves as in scenario 1.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS core's memory-side logic: arbiter FSM states and
// port-grant encoding, reused by the core's bus wrapper.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter between the core's fetch and data ports onto one
// Avalon-style bus, with registered bus outputs, acks and a wait-state watchdog.
module mips_mem_arbiter
    import mips_bus_pkg::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        instr_ack,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_ack,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        bus_error
);

    // A zero limit disables the watchdog, but the counter still needs one bit.
    localparam int         CW    = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(WAIT_LIMIT);

    arb_state_t    r_state;
    arb_state_t    w_nextState;
    grant_t        r_grant;
    grant_t        r_lastGrant;
    logic [CW-1:0] r_waitCount;
    logic [CW:0]   w_waitCountInc;
    logic          w_dataReq;
    logic          w_timeout;

    logic [31:0]   r_busAddress;
    logic          r_busRead;
    logic          r_busWrite;
    logic [31:0]   r_busWritedata;
    logic [3:0]    r_busByteenable;
    logic [31:0]   r_instrReaddata;
    logic [31:0]   r_dataReaddata;
    logic          r_instrAck;
    logic          r_dataAck;
    logic          r_busError;

    assign w_dataReq      = data_read | data_write;
    assign w_waitCountInc = {1'b0, r_waitCount} + (CW + 1)'(1);

    // The abort fires on the WAIT_LIMIT-th consecutive stalled cycle.
    assign w_timeout = (WAIT_LIMIT != 0) && bus_waitrequest && (w_waitCountInc == LIMIT);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (instr_req && (!w_dataReq || r_lastGrant == GRANT_D)) begin
                    w_nextState = BUS_I;
                end else if (w_dataReq) begin
                    w_nextState = BUS_D;
                end
            end
            BUS_I, BUS_D: begin
                if (!bus_waitrequest || w_timeout) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                if (r_instrAck || r_dataAck) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // RESP spends one cycle raising the ack and one cycle with it high, so a
    // requester dropping its request on the ack edge is never re-sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_grant         <= GRANT_I;
            r_lastGrant     <= GRANT_D;
            r_waitCount     <= '0;
            r_busAddress    <= '0;
            r_busRead       <= 1'b0;
            r_busWrite      <= 1'b0;
            r_busWritedata  <= '0;
            r_busByteenable <= '0;
            r_instrReaddata <= '0;
            r_dataReaddata  <= '0;
            r_instrAck      <= 1'b0;
            r_dataAck       <= 1'b0;
            r_busError      <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_nextState == BUS_I) begin
                        r_grant         <= GRANT_I;
                        r_waitCount     <= '0;
                        r_busAddress    <= instr_address;
                        r_busRead       <= 1'b1;
                        r_busWrite      <= 1'b0;
                        r_busWritedata  <= '0;
                        r_busByteenable <= BE_WORD;
                    end else if (w_nextState == BUS_D) begin
                        r_grant         <= GRANT_D;
                        r_waitCount     <= '0;
                        r_busAddress    <= data_address;
                        r_busRead       <= ~data_write;
                        r_busWrite      <= data_write;
                        r_busWritedata  <= data_writedata;
                        r_busByteenable <= data_byteenable;
                    end
                end
                BUS_I, BUS_D: begin
                    if (!bus_waitrequest) begin
                        r_busRead   <= 1'b0;
                        r_busWrite  <= 1'b0;
                        r_lastGrant <= r_grant;
                        if (r_busRead) begin
                            if (r_grant == GRANT_I) begin
                                r_instrReaddata <= bus_readdata;
                            end else begin
                                r_dataReaddata <= bus_readdata;
                            end
                        end
                    end else if (w_timeout) begin
                        r_busRead   <= 1'b0;
                        r_busWrite  <= 1'b0;
                        r_lastGrant <= r_grant;
                        r_busError  <= 1'b1;
                        if (r_grant == GRANT_I) begin
                            r_instrReaddata <= '0;
                        end else begin
                            r_dataReaddata <= '0;
                        end
                    end else begin
                        r_waitCount <= r_waitCount + CW'(1);
                    end
                end
                RESP: begin
                    if (!r_instrAck && !r_dataAck) begin
                        r_instrAck <= (r_grant == GRANT_I);
                        r_dataAck  <= (r_grant == GRANT_D);
                    end else begin
                        r_instrAck <= 1'b0;
                        r_dataAck  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_address    = r_busAddress;
    assign bus_read       = r_busRead;
    assign bus_write      = r_busWrite;
    assign bus_writedata  = r_busWritedata;
    assign bus_byteenable = r_busByteenable;
    assign instr_readdata = r_instrReaddata;
    assign data_readdata  = r_dataReaddata;
    assign instr_ack      = r_instrAck;
    assign data_ack       = r_dataAck;
    assign bus_error      = r_busError;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: requester agents push expected acks,
// a monitor pops them, and a bus slave model checks command stability.
module tb_mips_mem_arbiter;
    import mips_bus_pkg::*;

    localparam int WAIT_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_ack;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_ack;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest = 1'b0;
    logic [31:0] bus_readdata = 32'h0;
    logic        bus_error;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req       (instr_req),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .instr_ack       (instr_ack),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .data_ack        (data_ack),
        .bus_address     (bus_address),
        .bus_read        (bus_read),
        .bus_write       (bus_write),
        .bus_writedata   (bus_writedata),
        .bus_byteenable  (bus_byteenable),
        .bus_waitrequest (bus_waitrequest),
        .bus_readdata    (bus_readdata),
        .bus_error       (bus_error)
    );

    typedef struct packed {
        logic        checkData;
        logic [31:0] data;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t instrQ[$];
    exp_t dataQ[$];
    int   orderQ[$];

    int          slaveWaits    = 0;
    bit          slaveHang     = 1'b0;
    int          cmdCycles     = 0;
    int          lastCmdCycles = 0;
    logic [31:0] capAddr;
    logic [31:0] capWd;
    logic [3:0]  capBe;
    logic        capRead;
    logic        capWrite;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] memModel(input logic [31:0] addr);
        return (addr == 32'hBFC00000) ? 32'h24020005 : (addr ^ 32'hA5A5A5A5);
    endfunction

    // Bus slave: stalls the first slaveWaits command cycles (or forever when
    // hung) and checks the command holds steady across every stalled cycle.
    always @(negedge clk) begin
        if (bus_read || bus_write) begin
            if (cmdCycles == 0) begin
                capAddr  = bus_address;
                capWd    = bus_writedata;
                capBe    = bus_byteenable;
                capRead  = bus_read;
                capWrite = bus_write;
            end else begin
                checkOutput("stable bus_address", bus_address, capAddr);
                checkOutput("stable bus_writedata", bus_writedata, capWd);
                checkOutput("stable bus_byteenable", bus_byteenable, capBe);
                checkOutput("stable bus_read", bus_read, capRead);
                checkOutput("stable bus_write", bus_write, capWrite);
            end
            bus_waitrequest = slaveHang || (cmdCycles < slaveWaits);
            bus_readdata    = memModel(bus_address);
            cmdCycles++;
        end else begin
            if (cmdCycles != 0) lastCmdCycles = cmdCycles;
            cmdCycles       = 0;
            bus_waitrequest = slaveHang;
            bus_readdata    = 32'h0;
        end
    end

    // Monitor: every ack must match the next expected grant and readdata.
    always @(negedge clk) begin
        exp_t e;
        if (instr_ack || data_ack) begin
            checkOutput("ack exclusive", instr_ack & data_ack, 0);
            if (orderQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected ack: instr_ack=%b data_ack=%b, expected none", instr_ack, data_ack);
            end else begin
                checkOutput("grant order", instr_ack ? 0 : 1, orderQ.pop_front());
            end
            if (instr_ack) begin
                if (instrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected instr_ack: got 1, expected 0");
                end else begin
                    e = instrQ.pop_front();
                    if (e.checkData) checkOutput("instr_readdata", instr_readdata, e.data);
                end
            end
            if (data_ack) begin
                if (dataQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected data_ack: got 1, expected 0");
                end else begin
                    e = dataQ.pop_front();
                    if (e.checkData) checkOutput("data_readdata", data_readdata, e.data);
                end
            end
        end
    end

    // Requester agent: port 0 is fetch, port 1 is data. Latency counts clock
    // edges from the first sampling edge's predecessor to ack visibility.
    task automatic applyStimulus(input int port, input bit wr, input bit rd,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] be, input bit checkData,
                                 input logic [31:0] expData, input int expLat);
        exp_t e;
        bit   seen;
        int   lat;
        e.checkData = checkData;
        e.data      = expData;
        if (port == 0) begin
            instrQ.push_back(e);
            instr_address = addr;
            instr_req     = 1'b1;
        end else begin
            dataQ.push_back(e);
            data_address    = addr;
            data_writedata  = wd;
            data_byteenable = be;
            data_write      = wr;
            data_read       = rd;
        end
        seen = 1'b0;
        lat  = 0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            @(negedge clk);
            if ((port == 0 && instr_ack) || (port == 1 && data_ack)) begin
                seen = 1'b1;
                lat  = cyc - 1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack timeout port %0d: got no ack in 60 cycles, expected ack", port);
        end else if (expLat >= 0) begin
            checkOutput($sformatf("latency port %0d", port), lat, expLat);
        end
        @(posedge clk);
        #1;
        if (port == 0) begin
            instr_req = 1'b0;
        end else begin
            data_write = 1'b0;
            data_read  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        reset           = 1'b1;
        instr_req       = 1'b0;
        instr_address   = 32'h0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = 32'h0;
        data_writedata  = 32'h0;
        data_byteenable = 4'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset bus_read", bus_read, 0);
        checkOutput("reset bus_write", bus_write, 0);
        checkOutput("reset bus_address", bus_address, 0);
        checkOutput("reset instr_ack", instr_ack, 0);
        checkOutput("reset data_ack", data_ack, 0);
        checkOutput("reset instr_readdata", instr_readdata, 0);
        checkOutput("reset data_readdata", data_readdata, 0);
        checkOutput("reset bus_error", bus_error, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Simultaneous requests right after reset alternate I, D, I, D.
        orderQ.push_back(0);
        orderQ.push_back(1);
        orderQ.push_back(0);
        orderQ.push_back(1);
        fork
            begin
                applyStimulus(0, 0, 0, 32'h00400000, 32'h0, 4'h0, 1, 32'hA5E5A5A5, 3);
                applyStimulus(0, 0, 0, 32'h00400004, 32'h0, 4'h0, 1, 32'hA5E5A5A1, -1);
            end
            begin
                applyStimulus(1, 0, 1, 32'h00000200, 32'h0, 4'hF, 1, 32'hA5A5A7A5, 7);
                applyStimulus(1, 0, 1, 32'h00000204, 32'h0, 4'hF, 1, 32'hA5A5A7A1, -1);
            end
        join

        // Single zero-wait fetch.
        lastCmdCycles = 0;
        orderQ.push_back(0);
        applyStimulus(0, 0, 0, 32'hBFC00000, 32'h0, 4'h0, 1, 32'h24020005, 3);
        checkOutput("fetch bus_read cycles", lastCmdCycles, 1);
        checkOutput("fetch bus_byteenable", capBe, 4'hF);
        checkOutput("fetch bus_address", capAddr, 32'hBFC00000);
        checkOutput("fetch bus_read", capRead, 1);
        checkOutput("bus_error after fetch", bus_error, 0);

        // Store with two wait states; read asserted too, so write must win.
        slaveWaits    = 2;
        lastCmdCycles = 0;
        orderQ.push_back(1);
        applyStimulus(1, 1, 1, 32'h00001000, 32'hDEADBEEF, 4'b0011, 0, 32'h0, 5);
        slaveWaits = 0;
        checkOutput("store command cycles", lastCmdCycles, 3);
        checkOutput("store bus_write", capWrite, 1);
        checkOutput("store bus_read", capRead, 0);
        checkOutput("store bus_address", capAddr, 32'h00001000);
        checkOutput("store bus_writedata", capWd, 32'hDEADBEEF);
        checkOutput("store bus_byteenable", capBe, 4'b0011);

        // Hung slave: watchdog aborts after WAIT_LIMIT stalled cycles.
        slaveHang     = 1'b1;
        lastCmdCycles = 0;
        orderQ.push_back(0);
        applyStimulus(0, 0, 0, 32'h00000040, 32'h0, 4'h0, 1, 32'h0, 6);
        slaveHang = 1'b0;
        checkOutput("watchdog command cycles", lastCmdCycles, 4);
        checkOutput("watchdog bus_error", bus_error, 1);
        orderQ.push_back(1);
        applyStimulus(1, 0, 1, 32'h00000300, 32'h0, 4'hF, 1, 32'hA5A5A6A5, 3);
        checkOutput("bus_error sticky", bus_error, 1);

        // Reset during a stalled store: command drops with no ack.
        slaveHang       = 1'b1;
        data_address    = 32'h00002000;
        data_writedata  = 32'h12345678;
        data_byteenable = 4'hF;
        data_write      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        data_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid reset bus_write", bus_write, 0);
        checkOutput("mid reset bus_read", bus_read, 0);
        checkOutput("mid reset data_ack", data_ack, 0);
        checkOutput("mid reset bus_error", bus_error, 0);
        checkOutput("mid reset data_readdata", data_readdata, 0);
        checkOutput("mid reset instr_readdata", instr_readdata, 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        slaveHang = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Post-reset fetch behaves like the first single fetch.
        lastCmdCycles = 0;
        orderQ.push_back(0);
        applyStimulus(0, 0, 0, 32'hBFC00000, 32'h0, 4'h0, 1, 32'h24020005, 3);
        checkOutput("post reset bus_read cycles", lastCmdCycles, 1);
        checkOutput("post reset bus_byteenable", capBe, 4'hF);

        repeat (3) @(posedge clk);
        checkOutput("scoreboard drained", orderQ.size() + instrQ.size() + dataQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
